// File: rtl/mu_alu_requester_if.sv
// Bundle of the delta stream, the adder request/response pair and the
// ledger status outputs of the mu-cost requester.
// The master modport is the requester's view; the slave modport is the
// view of whatever surrounds it (producers plus adder responder).
interface mu_alu_requester_if #(
    parameter int WIDTH = 32
);
    logic             delta_valid;
    logic             delta_ready;
    logic [WIDTH-1:0] delta;
    logic             clear;
    logic [WIDTH-1:0] alu_operand_a;
    logic [WIDTH-1:0] alu_operand_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ready;
    logic [WIDTH-1:0] mu_total;
    logic             commit;
    logic             overflow;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  delta_valid, delta, clear, alu_result, alu_ready,
        output delta_ready, alu_operand_a, alu_operand_b, mu_total,
               commit, overflow, timeout_err, busy
    );

    modport slave (
        output delta_valid, delta, clear, alu_result, alu_ready,
        input  delta_ready, alu_operand_a, alu_operand_b, mu_total,
               commit, overflow, timeout_err, busy
    );
endinterface

// File: rtl/mu_alu_requester.sv
// Initiator-side sequencer for the mu-cost adder. Accepts a delta, sends
// {running total, delta} to the adder, waits for its result and commits it
// as the new ledger total. A carry out of the adder saturates the total and
// sets a sticky overflow flag; a responder that never answers is abandoned
// after TIMEOUT wait cycles and flagged with a sticky timeout error.
module mu_alu_requester #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mu_alu_requester_if.master   bus
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       timer;
    logic             accept;
    logic             do_commit;
    logic             do_timeout;
    logic [WIDTH-1:0] operand_a_q;
    logic [WIDTH-1:0] operand_b_q;
    logic [WIDTH-1:0] total_q;
    logic             commit_q;
    logic             overflow_q;
    logic             timeout_q;

    assign bus.delta_ready   = (state == IDLE) && !bus.clear;
    assign bus.busy          = (state == WAIT);
    assign bus.alu_operand_a = operand_a_q;
    assign bus.alu_operand_b = operand_b_q;
    assign bus.mu_total      = total_q;
    assign bus.commit        = commit_q;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_err   = timeout_q;

    // State register; reset or clear always lands in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the accept / commit / abandon strobes; clear overrides everything.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        do_commit  = 1'b0;
        do_timeout = 1'b0;
        if (bus.clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.delta_valid) begin
                        accept     = 1'b1;
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.alu_ready) begin
                        do_commit  = 1'b1;
                        next_state = IDLE;
                    end else if (timer == TIMER_LAST) begin
                        do_timeout = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: capture operands on accept, commit or saturate the total, run the wait timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_a_q <= '0;
            operand_b_q <= '0;
            total_q     <= '0;
            commit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            timer       <= '0;
        end else begin
            commit_q <= do_commit;
            if (bus.clear) begin
                total_q    <= '0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
                timer      <= '0;
            end else begin
                if (accept) begin
                    operand_a_q <= total_q;
                    operand_b_q <= bus.delta;
                    timer       <= '0;
                end
                if (do_commit) begin
                    if (bus.alu_result < operand_a_q) begin
                        total_q    <= '1;
                        overflow_q <= 1'b1;
                    end else begin
                        total_q <= bus.alu_result;
                    end
                end else if (do_timeout) begin
                    timeout_q <= 1'b1;
                end else if (state == WAIT) begin
                    timer <= timer + 8'd1;
                end
            end
        end
    end

endmodule
